mem_port_arbiter: RTL and testbench

// Shares the single LoadStoreUnit memory port between two requesters:

---
 rtl/mem_arb_pkg.sv | 9 +
 rtl/rr_arbiter2.sv | 18 +
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
    typedef enum logic {REQ_IF = 1'b0, REQ_D = 1'b1} req_id_t;

    localparam logic [2:0] FUNCT3_LW = 3'b010;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant, bit 0 = IF, bit 1 = D
import mem_arb_pkg::*;

module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        // On a tie the requester that did not win last time goes first.
        if (req == 2'b11) begin
            grant = (req_id_t'(last_grant) == REQ_D) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one LoadStoreUnit port between fetch and data
import mem_arb_pkg::*;

module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wren,
    input  logic [2:0]        d_funct3,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_wren,
    output logic [2:0]        mem_funct3,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

    arb_state_t        state, next_state;
    req_id_t           last_grant, lat_id, win;
    logic [1:0]        grant;
    logic [1:0]        cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_wren;
    logic [2:0]        lat_funct3;
    logic [DATA_W-1:0] lat_wdata;
    logic              accept;
    logic [DATA_W-1:0] rsp_word;

    rr_arbiter2 u_rr (
        .req        ({d_req_valid, if_req_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign win      = grant[1] ? REQ_D : REQ_IF;
    assign accept   = (state == IDLE) && (grant != 2'b00);
    assign rsp_word = lat_wren ? '0 : mem_dout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= REQ_D;
            lat_id      <= REQ_IF;
            cnt         <= '0;
            lat_addr    <= '0;
            lat_wren    <= 1'b0;
            lat_funct3  <= '0;
            lat_wdata   <= '0;
            if_rsp_data <= '0;
            d_rsp_data  <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                last_grant <= win;
                lat_id     <= win;
                cnt        <= CNT_INIT;
                lat_addr   <= (win == REQ_D) ? d_addr : if_addr;
                lat_wren   <= (win == REQ_D) && d_wren;
                lat_funct3 <= (win == REQ_D) ? d_funct3 : FUNCT3_LW;
                lat_wdata  <= (win == REQ_D) ? d_wdata : '0;
            end else if (state == ACCESS && cnt != 2'd0) begin
                cnt <= cnt - 2'd1;
            end
            // Response data is captured on the edge that ends the last access cycle.
            if (state == ACCESS && cnt == 2'd0) begin
                if (lat_id == REQ_D) d_rsp_data  <= rsp_word;
                else                 if_rsp_data <= rsp_word;
            end
        end
    end

    always_comb begin
        next_state   = state;
        if_req_ready = 1'b0;
        d_req_ready  = 1'b0;
        if_rsp_valid = 1'b0;
        d_rsp_valid  = 1'b0;
        mem_address  = '0;
        mem_wren     = 1'b0;
        mem_funct3   = '0;
        mem_din      = '0;
        busy         = 1'b0;
        // Outputs are forced low while reset is held so an abort is visible at once.
        if (!reset) begin
            busy = (state != IDLE);
            case (state)
                IDLE: begin
                    if_req_ready = grant[0];
                    d_req_ready  = grant[1];
                    if (accept) next_state = ACCESS;
                end
                ACCESS: begin
                    mem_address = lat_addr;
                    mem_funct3  = lat_funct3;
                    mem_din     = lat_wdata;
                    mem_wren    = lat_wren && (cnt == CNT_INIT);
                    if (cnt == 2'd0) next_state = RESP;
                end
                RESP: begin
                    if_rsp_valid = (lat_id == REQ_IF);
                    d_rsp_valid  = (lat_id == REQ_D);
                    next_state   = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench, instances with MEM_LAT 1, 2 and 3
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req_valid = 1'b0;
    logic [31:0] if_addr = '0;
    logic        d_req_valid = 1'b0;
    logic [31:0] d_addr = '0;
    logic        d_wren = 1'b0;
    logic [2:0]  d_funct3 = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] mem_dout = '0;

    logic [2:0]  if_req_ready, if_rsp_valid, d_req_ready, d_rsp_valid, mem_wren, busy;
    logic [31:0] if_rsp_data [3];
    logic [31:0] d_rsp_data [3];
    logic [31:0] mem_address [3];
    logic [31:0] mem_din [3];
    logic [2:0]  mem_funct3 [3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g + 1)) u_dut (
            .clk          (clk),
            .reset        (reset),
            .if_req_valid (if_req_valid),
            .if_req_ready (if_req_ready[g]),
            .if_addr      (if_addr),
            .if_rsp_valid (if_rsp_valid[g]),
            .if_rsp_data  (if_rsp_data[g]),
            .d_req_valid  (d_req_valid),
            .d_req_ready  (d_req_ready[g]),
            .d_addr       (d_addr),
            .d_wren       (d_wren),
            .d_funct3     (d_funct3),
            .d_wdata      (d_wdata),
            .d_rsp_valid  (d_rsp_valid[g]),
            .d_rsp_data   (d_rsp_data[g]),
            .mem_address  (mem_address[g]),
            .mem_wren     (mem_wren[g]),
            .mem_funct3   (mem_funct3[g]),
            .mem_din      (mem_din[g]),
            .mem_dout     (mem_dout),
            .busy         (busy[g])
        );
    end

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic [31:0] da;
        logic        dw;
        logic [2:0]  df;
        logic [31:0] wd;
        logic [31:0] md;
        logic        irdy;
        logic        ivld;
        logic [31:0] idat;
        logic        drdy;
        logic        dvld;
        logic [31:0] ddat;
        logic        mw;
        logic [31:0] maddr;
        logic [2:0]  mf;
        logic [31:0] mdin;
        logic        bsy;
    } vec_t;

    vec_t vecs [26];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic iv, input logic [31:0] ia, input logic dv,
                         input logic [31:0] da, input logic dw, input logic [2:0] df,
                         input logic [31:0] wd, input logic [31:0] md);
        reset = rst; if_req_valid = iv; if_addr = ia; d_req_valid = dv;
        d_addr = da; d_wren = dw; d_funct3 = df; d_wdata = wd; mem_dout = md;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, '0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int if_seen, d_seen, addr_hits;
        logic [31:0] p, q1, q2, q3, q4;
        p = 32'h00500093; q1 = 32'h11111111; q2 = 32'h22222222; q3 = 32'h33333333; q4 = 32'h44444444;

        // rst iv ia dv da dw df wd md | irdy ivld idat drdy dvld ddat mw maddr mf mdin bsy  (instance MEM_LAT=1)
        vecs[0]  = '{1, 1, 32'h10, 1, 32'h40, 0, 3'b010, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 3'b000, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0,  0, 0, 0,  0, 0, 3'b000, 0, 0};
        vecs[2]  = '{0, 1, 32'h10, 0, 0, 0, 0, 0, p,            1, 0, 0,  0, 0, 0,  0, 0, 3'b000, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, p,                 0, 0, 0,  0, 0, 0,  0, 32'h10, 3'b010, 0, 1};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 1, p,  0, 0, 0,  0, 0, 3'b000, 0, 1};
        vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, p,  0, 0, 0,  0, 0, 3'b000, 0, 0};
        vecs[6]  = '{0, 0, 0, 1, 32'h40, 1, 3'b010, 32'hDEADBEEF, p, 0, 0, p, 1, 0, 0, 0, 0, 3'b000, 0, 0};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h12345678,      0, 0, p,  0, 0, 0,  1, 32'h40, 3'b010, 32'hDEADBEEF, 1};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, p,  0, 1, 0,  0, 0, 3'b000, 0, 1};
        vecs[9]  = '{0, 1, 32'h100, 1, 32'h200, 0, 3'b010, 0, 0,  1, 0, p,  0, 0, 0,  0, 0, 3'b000, 0, 0};
        vecs[10] = '{0, 1, 32'h100, 1, 32'h200, 0, 3'b010, 0, q1, 0, 0, p,  0, 0, 0,  0, 32'h100, 3'b010, 0, 1};
        vecs[11] = '{0, 1, 32'h100, 1, 32'h200, 0, 3'b010, 0, 0,  0, 1, q1, 0, 0, 0,  0, 0, 3'b000, 0, 1};
        vecs[12] = '{0, 1, 32'h100, 1, 32'h200, 0, 3'b010, 0, 0,  0, 0, q1, 1, 0, 0,  0, 0, 3'b000, 0, 0};
        vecs[13] = '{0, 1, 32'h100, 1, 32'h200, 0, 3'b010, 0, q2, 0, 0, q1, 0, 0, 0,  0, 32'h200, 3'b010, 0, 1};
        vecs[14] = '{0, 1, 32'h100, 1, 32'h200, 0, 3'b010, 0, 0,  0, 0, q1, 0, 1, q2, 0, 0, 3'b000, 0, 1};
        vecs[15] = '{0, 1, 32'h100, 1, 32'h200, 0, 3'b010, 0, 0,  1, 0, q1, 0, 0, q2, 0, 0, 3'b000, 0, 0};
        vecs[16] = '{0, 1, 32'h100, 1, 32'h200, 0, 3'b010, 0, q3, 0, 0, q1, 0, 0, q2, 0, 32'h100, 3'b010, 0, 1};
        vecs[17] = '{0, 1, 32'h100, 1, 32'h200, 0, 3'b010, 0, 0,  0, 1, q3, 0, 0, q2, 0, 0, 3'b000, 0, 1};
        vecs[18] = '{0, 1, 32'h100, 1, 32'h200, 0, 3'b010, 0, 0,  0, 0, q3, 1, 0, q2, 0, 0, 3'b000, 0, 0};
        vecs[19] = '{0, 1, 32'h100, 1, 32'h200, 0, 3'b010, 0, q4, 0, 0, q3, 0, 0, q2, 0, 32'h200, 3'b010, 0, 1};
        vecs[20] = '{0, 1, 32'h100, 1, 32'h200, 0, 3'b010, 0, 0,  0, 0, q3, 0, 1, q4, 0, 0, 3'b000, 0, 1};
        vecs[21] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, q3, 0, 0, q4, 0, 0, 3'b000, 0, 0};
        vecs[22] = '{0, 0, 0, 1, 32'h44, 1, 3'b001, 32'h0000BEEF, 32'h55555555, 0, 0, q3, 1, 0, q4, 0, 0, 3'b000, 0, 0};
        vecs[23] = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h55555555,      0, 0, q3, 0, 0, q4, 1, 32'h44, 3'b001, 32'h0000BEEF, 1};
        vecs[24] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, q3, 0, 1, 0,  0, 0, 3'b000, 0, 1};
        vecs[25] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, q3, 0, 0, 0,  0, 0, 3'b000, 0, 0};

        for (int i = 0; i < 26; i++) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].ia, vecs[i].dv, vecs[i].da,
                  vecs[i].dw, vecs[i].df, vecs[i].wd, vecs[i].md);
            @(negedge clk);
            chk($sformatf("v%0d if_req_ready", i), 32'(if_req_ready[0]), 32'(vecs[i].irdy));
            chk($sformatf("v%0d if_rsp_valid", i), 32'(if_rsp_valid[0]), 32'(vecs[i].ivld));
            chk($sformatf("v%0d if_rsp_data", i), if_rsp_data[0], vecs[i].idat);
            chk($sformatf("v%0d d_req_ready", i), 32'(d_req_ready[0]), 32'(vecs[i].drdy));
            chk($sformatf("v%0d d_rsp_valid", i), 32'(d_rsp_valid[0]), 32'(vecs[i].dvld));
            chk($sformatf("v%0d d_rsp_data", i), d_rsp_data[0], vecs[i].ddat);
            chk($sformatf("v%0d mem_wren", i), 32'(mem_wren[0]), 32'(vecs[i].mw));
            chk($sformatf("v%0d mem_address", i), mem_address[0], vecs[i].maddr);
            chk($sformatf("v%0d mem_funct3", i), 32'(mem_funct3[0]), 32'(vecs[i].mf));
            chk($sformatf("v%0d mem_din", i), mem_din[0], vecs[i].mdin);
            chk($sformatf("v%0d busy", i), 32'(busy[0]), 32'(vecs[i].bsy));
            tick();
        end

        // MEM_LAT=3 LBU load: funct3 held T+1..T+3, response T+4, next accept T+5.
        do_reset();
        drive(1'b0, 1'b0, '0, 1'b1, 32'h13, 1'b0, 3'b100, '0, '0);
        @(negedge clk);
        chk("lbu accept", 32'(d_req_ready[2]), 32'd1);
        tick();
        for (int k = 1; k <= 3; k++) begin
            mem_dout = (k == 3) ? 32'hA5A5A5A5 : 32'h0;
            @(negedge clk);
            chk($sformatf("lbu T+%0d mem_funct3", k), 32'(mem_funct3[2]), 32'd4);
            chk($sformatf("lbu T+%0d mem_address", k), mem_address[2], 32'h13);
            chk($sformatf("lbu T+%0d ready", k), 32'(d_req_ready[2]), 32'd0);
            chk($sformatf("lbu T+%0d rsp_valid", k), 32'(d_rsp_valid[2]), 32'd0);
            tick();
        end
        mem_dout = 32'h0;
        @(negedge clk);
        chk("lbu T+4 rsp_valid", 32'(d_rsp_valid[2]), 32'd1);
        chk("lbu T+4 rsp_data", d_rsp_data[2], 32'hA5A5A5A5);
        chk("lbu T+4 ready", 32'(d_req_ready[2]), 32'd0);
        tick();
        @(negedge clk);
        chk("lbu T+5 ready", 32'(d_req_ready[2]), 32'd1);
        tick();
        d_req_valid = 1'b0;

        // MEM_LAT=2 store aborted by reset at T+1.
        do_reset();
        drive(1'b0, 1'b0, '0, 1'b1, 32'h80, 1'b1, 3'b010, 32'hCAFEF00D, '0);
        @(negedge clk);
        chk("abort accept", 32'(d_req_ready[1]), 32'd1);
        tick();
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("abort T+1 mem_wren", 32'(mem_wren[1]), 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("abort T+2 mem_address", mem_address[1], 32'h0);
        chk("abort T+2 mem_din", mem_din[1], 32'h0);
        chk("abort T+2 mem_ctl", {mem_funct3[1], 26'h0, mem_wren[1], busy[1], if_req_ready[1], d_req_ready[1]}, 32'h0);
        chk("abort T+2 rsp", {28'h0, if_rsp_valid[1], d_rsp_valid[1], 2'b00}, 32'h0);
        chk("abort T+2 d_rsp_data", d_rsp_data[1], 32'h0);
        chk("abort T+2 if_rsp_data", if_rsp_data[1], 32'h0);
        d_seen = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            d_seen += int'(d_rsp_valid[1]) + int'(if_rsp_valid[1]);
        end
        chk("abort no response", d_seen, 32'd0);
        tick();
        if_req_valid = 1'b1; d_req_valid = 1'b1;
        @(negedge clk);
        chk("abort tie if_ready", 32'(if_req_ready[1]), 32'd1);
        chk("abort tie d_ready", 32'(d_req_ready[1]), 32'd0);
        tick();

        // last_grant returns to D on reset even after an IF win.
        do_reset();
        drive(1'b0, 1'b1, 32'h4, 1'b0, '0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("rst-rr if accept", 32'(if_req_ready[0]), 32'd1);
        tick();
        if_req_valid = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        do_reset();
        if_req_valid = 1'b1; d_req_valid = 1'b1;
        @(negedge clk);
        chk("rst-rr if_ready", 32'(if_req_ready[0]), 32'd1);
        chk("rst-rr d_ready", 32'(d_req_ready[0]), 32'd0);
        tick();

        // IF valid withdrawn while a MEM_LAT=3 load is in flight.
        do_reset();
        drive(1'b0, 1'b0, '0, 1'b1, 32'h20, 1'b0, 3'b010, '0, 32'h77777777);
        @(negedge clk);
        chk("drop d accept", 32'(d_req_ready[2]), 32'd1);
        tick();
        drive(1'b0, 1'b1, 32'h30, 1'b0, '0, 1'b0, '0, '0, 32'h77777777);
        @(negedge clk);
        chk("drop if not ready", 32'(if_req_ready[2]), 32'd0);
        tick();
        if_req_valid = 1'b0;
        if_seen = 0; d_seen = 0; addr_hits = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if_seen += int'(if_rsp_valid[2]) + int'(if_req_ready[2]);
            d_seen += int'(d_rsp_valid[2]);
            addr_hits += int'(mem_address[2] == 32'h30);
            tick();
        end
        chk("drop no if activity", if_seen, 32'd0);
        chk("drop d responses", d_seen, 32'd1);
        chk("drop no if address", addr_hits, 32'd0);
        chk("drop d data", d_rsp_data[2], 32'h77777777);
        chk("drop idle", 32'(busy[2]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
